// File: rtl/sensor_pkg.sv
// Shared sensor definitions: channel count, data widths, channel ids and the
// alarm event record carried through the event queue.
package sensor_pkg;
  localparam int NUM_SENSORS   = 5;
  localparam int SENSOR_DATA_W = 16;
  localparam int CH_ID_W       = 3;

  localparam logic [CH_ID_W-1:0] CH_TEMP      = 3'd0;
  localparam logic [CH_ID_W-1:0] CH_HUMIDITY  = 3'd1;
  localparam logic [CH_ID_W-1:0] CH_DEW       = 3'd2;
  localparam logic [CH_ID_W-1:0] CH_MOISTURE  = 3'd3;
  localparam logic [CH_ID_W-1:0] CH_WATER_LVL = 3'd4;

  typedef struct packed {
    logic [CH_ID_W-1:0]       ch_id;
    logic [SENSOR_DATA_W-1:0] data;
  } sensor_evt_t;
endpackage

// File: rtl/sensor_event_queue_if.sv
// Valid/ready event stream from the sensor event queue to the host/logging stage.
interface sensor_event_queue_if
  import sensor_pkg::*;
#(
  parameter int DATA_W = SENSOR_DATA_W,
  parameter int CH_W   = CH_ID_W
);
  logic              evt_valid;
  logic              evt_ready;
  logic [CH_W-1:0]   evt_ch;
  logic [DATA_W-1:0] evt_data;

  modport master (output evt_valid, output evt_ch, output evt_data, input evt_ready);
  modport slave  (input evt_valid, input evt_ch, input evt_data, output evt_ready);
endinterface

// File: rtl/sensor_event_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count. Pushes while
// full and pops while empty are ignored; the caller decides what gets lost.
module sensor_event_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && (count_q != '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop)      count_d = count_q + (PTR_W+1)'(1);
    else if (!do_push && do_pop) count_d = count_q - (PTR_W+1)'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible once the count covers them.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end
endmodule

// File: rtl/sensor_event_queue.sv
// Turns per-channel threshold-reached edges into rate-limited alarm events,
// arbitrates them round-robin into an event FIFO, and tracks sticky status.
module sensor_event_queue
  import sensor_pkg::*;
#(
  parameter int NUM_CH     = NUM_SENSORS,
  parameter int DATA_W     = SENSOR_DATA_W,
  parameter int FIFO_DEPTH = 8,
  parameter int HOLDOFF    = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CH-1:0]             ch_reached,
  input  logic [NUM_CH*DATA_W-1:0]      ch_data,
  input  logic [NUM_CH-1:0]             alarm_clear,
  input  logic                          overflow_clr,
  sensor_event_queue_if.master          evt,
  output logic [NUM_CH-1:0]             alarm_status,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);
  localparam int HOLD_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF);
  localparam int EVT_W = CH_ID_W + DATA_W;

  logic [NUM_CH-1:0]  reached_q;
  logic [NUM_CH-1:0]  pend_q, pend_d;
  logic [DATA_W-1:0]  pend_data_q [NUM_CH];
  logic [DATA_W-1:0]  pend_data_d [NUM_CH];
  logic [HOLD_W-1:0]  hold_cnt_q [NUM_CH];
  logic [HOLD_W-1:0]  hold_cnt_d [NUM_CH];
  logic [NUM_CH-1:0]  alarm_q, alarm_d;
  logic               ovf_q, ovf_d;
  logic [CH_ID_W-1:0] rr_ptr_q, rr_ptr_d;

  logic [NUM_CH-1:0]  trig;
  logic [NUM_CH-1:0]  grant;
  logic               grant_vld;
  logic [CH_ID_W-1:0] grant_idx;
  logic [DATA_W-1:0]  grant_data;
  logic               fifo_full;
  logic [EVT_W-1:0]   fifo_head;

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      trig[k] = ch_reached[k] && !reached_q[k] && (hold_cnt_q[k] == '0);
    end
  end

  // Round-robin: first pending channel at or above rr_ptr, else lowest pending.
  always_comb begin
    grant_vld  = 1'b0;
    grant_idx  = '0;
    grant_data = '0;
    if (!fifo_full) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (!grant_vld && pend_q[k] && (CH_ID_W'(k) >= rr_ptr_q)) begin
          grant_vld  = 1'b1;
          grant_idx  = CH_ID_W'(k);
          grant_data = pend_data_q[k];
        end
      end
      for (int k = 0; k < NUM_CH; k++) begin
        if (!grant_vld && pend_q[k]) begin
          grant_vld  = 1'b1;
          grant_idx  = CH_ID_W'(k);
          grant_data = pend_data_q[k];
        end
      end
    end
    for (int k = 0; k < NUM_CH; k++) begin
      grant[k] = grant_vld && (grant_idx == CH_ID_W'(k));
    end
  end

  always_comb begin
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    hold_cnt_d  = hold_cnt_q;
    alarm_d     = (alarm_q & ~alarm_clear) | trig;
    ovf_d       = ovf_q;
    rr_ptr_d    = rr_ptr_q;
    if (overflow_clr) ovf_d = 1'b0;
    if (|(trig & pend_q & ~grant)) ovf_d = 1'b1;
    if (grant_vld) begin
      rr_ptr_d = (grant_idx == CH_ID_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_ID_W'(1);
    end
    // A same-cycle trigger re-fills the slot whose old contents are being pushed.
    for (int k = 0; k < NUM_CH; k++) begin
      if (hold_cnt_q[k] != '0) hold_cnt_d[k] = hold_cnt_q[k] - HOLD_W'(1);
      if (grant[k]) pend_d[k] = 1'b0;
      if (trig[k]) begin
        pend_d[k]      = 1'b1;
        pend_data_d[k] = ch_data[k*DATA_W +: DATA_W];
        hold_cnt_d[k]  = HOLD_LOAD;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reached_q <= '0;
      pend_q    <= '0;
      alarm_q   <= '0;
      ovf_q     <= 1'b0;
      rr_ptr_q  <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        pend_data_q[k] <= '0;
        hold_cnt_q[k]  <= '0;
      end
    end else begin
      reached_q   <= ch_reached;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      hold_cnt_q  <= hold_cnt_d;
      alarm_q     <= alarm_d;
      ovf_q       <= ovf_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  sensor_event_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (grant_vld),
    .push_data_i ({grant_idx, grant_data}),
    .pop_i       (evt.evt_ready),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .full_o      (fifo_full)
  );

  assign evt.evt_valid             = (fifo_count != '0);
  assign {evt.evt_ch, evt.evt_data} = fifo_head;
  assign alarm_status              = alarm_q;
  assign overflow                  = ovf_q;
endmodule

// File: tb/tb_sensor_event_queue.sv
// Self-checking bench for sensor_event_queue: directed scenarios plus random
// traffic, all checked every cycle against a queue-based behavioural model.
module tb_sensor_event_queue;
  import sensor_pkg::*;

  localparam int NUM_CH  = 5;
  localparam int DATA_W  = 16;
  localparam int DEPTH   = 8;
  localparam int HOLDOFF = 16;

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic [NUM_CH-1:0]        chReached = '0;
  logic [NUM_CH*DATA_W-1:0] chData = '0;
  logic [NUM_CH-1:0]        alarmClear = '0;
  logic                     overflowClr = 1'b0;
  logic                     evtReady = 1'b0;
  logic [NUM_CH-1:0]        alarmStatus;
  logic [$clog2(DEPTH):0]   fifoCount;
  logic                     overflowFlag;

  int total = 0;
  int bad = 0;

  sensor_event_queue_if #(.DATA_W(DATA_W), .CH_W(CH_ID_W)) evt ();
  assign evt.evt_ready = evtReady;

  sensor_event_queue #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .HOLDOFF(HOLDOFF)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ch_reached   (chReached),
    .ch_data      (chData),
    .alarm_clear  (alarmClear),
    .overflow_clr (overflowClr),
    .evt          (evt),
    .alarm_status (alarmStatus),
    .fifo_count   (fifoCount),
    .overflow     (overflowFlag)
  );

  always #5 clk = ~clk;

  // Behavioural model: events as a queue, holdoff as the first cycle a channel may trigger again.
  sensor_evt_t       mQ[$];
  logic [NUM_CH-1:0] mPend, mReached, mAlarm;
  logic [DATA_W-1:0] mPendData [NUM_CH];
  int                mHoldUntil [NUM_CH];
  int                mRr;
  int                mCycle = 0;
  logic              mOvf;

  task automatic modelReset();
    mQ.delete();
    mPend = '0; mReached = '0; mAlarm = '0; mOvf = 1'b0; mRr = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      mPendData[k] = '0;
      mHoldUntil[k] = 0;
    end
  endtask

  task automatic modelStep();
    logic [NUM_CH-1:0] trig;
    sensor_evt_t e;
    int g;
    bit ovfSet;
    mCycle++;
    for (int k = 0; k < NUM_CH; k++)
      trig[k] = chReached[k] && !mReached[k] && (mCycle >= mHoldUntil[k]);
    g = -1;
    if (mQ.size() < DEPTH) begin
      for (int i = 0; i < NUM_CH; i++) begin
        int c = (mRr + i) % NUM_CH;
        if (g < 0 && mPend[c]) g = c;
      end
    end
    if (mQ.size() != 0 && evtReady) void'(mQ.pop_front());
    if (g >= 0) begin
      e.ch_id = 3'(g);
      e.data = mPendData[g];
      mQ.push_back(e);
      mPend[g] = 1'b0;
      mRr = (g + 1) % NUM_CH;
    end
    ovfSet = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (trig[k]) begin
        if (mPend[k] && g != k) ovfSet = 1'b1;
        mPend[k] = 1'b1;
        mPendData[k] = chData[k*DATA_W +: DATA_W];
        mHoldUntil[k] = mCycle + HOLDOFF + 1;
      end
    end
    mAlarm = (mAlarm & ~alarmClear) | trig;
    if (ovfSet) mOvf = 1'b1;
    else if (overflowClr) mOvf = 1'b0;
    mReached = chReached;
  endtask

  initial begin
    modelReset();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) modelReset();
      else modelStep();
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      checkOutput("model evt_valid", 32'(evt.evt_valid), 32'(mQ.size() != 0));
      checkOutput("model fifo_count", 32'(fifoCount), 32'(mQ.size()));
      if (mQ.size() != 0) begin
        checkOutput("model evt_ch", 32'(evt.evt_ch), 32'(mQ[0].ch_id));
        checkOutput("model evt_data", 32'(evt.evt_data), 32'(mQ[0].data));
      end
      checkOutput("model alarm_status", 32'(alarmStatus), 32'(mAlarm));
      checkOutput("model overflow", 32'(overflowFlag), 32'(mOvf));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input int readyPct);
    for (int k = 0; k < NUM_CH; k++) begin
      if ($urandom_range(0, 5) == 0) chReached[k] = ~chReached[k];
      chData[k*DATA_W +: DATA_W] = 16'($urandom);
      alarmClear[k] = ($urandom_range(0, 19) == 0);
    end
    evtReady = ($urandom_range(0, 99) < readyPct);
    overflowClr = ($urandom_range(0, 29) == 0);
  endtask

  initial begin
    tick(3);
    checkOutput("reset evt_valid", 32'(evt.evt_valid), 0);
    checkOutput("reset fifo_count", 32'(fifoCount), 0);
    checkOutput("reset alarm_status", 32'(alarmStatus), 0);
    reset = 1'b1;

    // All channels at once drain in channel order, one per cycle.
    for (int k = 0; k < NUM_CH; k++) chData[k*DATA_W +: DATA_W] = 16'h00A0 + 16'(k);
    chReached = '1;
    evtReady = 1'b1;
    tick(1);
    chReached = '0;
    checkOutput("burst count before push", 32'(fifoCount), 0);
    tick(1);
    checkOutput("burst first ch", 32'(evt.evt_ch), 0);
    checkOutput("burst first data", 32'(evt.evt_data), 32'h00A0);
    checkOutput("burst first count", 32'(fifoCount), 1);
    for (int k = 1; k < NUM_CH; k++) begin
      tick(1);
      checkOutput("burst ch", 32'(evt.evt_ch), 32'(k));
      checkOutput("burst data", 32'(evt.evt_data), 32'h00A0 + 32'(k));
      checkOutput("burst count", 32'(fifoCount), 1);
    end
    tick(1);
    checkOutput("burst drained", 32'(fifoCount), 0);

    // Single event latency and level-held input.
    tick(20);
    alarmClear = '1;
    evtReady = 1'b0;
    tick(1);
    alarmClear = '0;
    chData[0 +: DATA_W] = 16'h1234;
    chReached[0] = 1'b1;
    tick(1);
    checkOutput("single valid at trig", 32'(evt.evt_valid), 0);
    tick(1);
    checkOutput("single valid", 32'(evt.evt_valid), 1);
    checkOutput("single ch", 32'(evt.evt_ch), 0);
    checkOutput("single data", 32'(evt.evt_data), 32'h1234);
    checkOutput("single alarm", 32'(alarmStatus), 32'b00001);
    tick(1);
    chReached[0] = 1'b0;
    tick(4);
    checkOutput("single one event", 32'(fifoCount), 1);
    evtReady = 1'b1;
    tick(1);
    checkOutput("single popped", 32'(fifoCount), 0);

    // Holdoff on channel 1.
    tick(20);
    evtReady = 1'b0;
    chData[1*DATA_W +: DATA_W] = 16'h0B01;
    chReached[1] = 1'b1;
    tick(2);
    chReached[1] = 1'b0;
    tick(3);
    chData[1*DATA_W +: DATA_W] = 16'h0B02;
    chReached[1] = 1'b1;
    tick(3);
    checkOutput("holdoff rise ignored", 32'(fifoCount), 1);
    chReached[1] = 1'b0;
    tick(12);
    chData[1*DATA_W +: DATA_W] = 16'h0B03;
    chReached[1] = 1'b1;
    tick(2);
    checkOutput("holdoff rearmed", 32'(fifoCount), 2);
    chReached[1] = 1'b0;
    evtReady = 1'b1;
    tick(3);

    // Fill the FIFO, park ch2 in pend, then overwrite it.
    tick(20);
    evtReady = 1'b0;
    for (int k = 0; k < NUM_CH; k++) chData[k*DATA_W +: DATA_W] = 16'h0C00 + 16'(k);
    chReached = '1;
    tick(1);
    chReached = '0;
    tick(20);
    chReached = 5'b01011;
    tick(1);
    chReached = '0;
    tick(6);
    checkOutput("full count", 32'(fifoCount), DEPTH);
    chData[CH_DEW*DATA_W +: DATA_W] = 16'h0111;
    chReached[CH_DEW] = 1'b1;
    tick(1);
    chReached = '0;
    tick(3);
    checkOutput("full still full", 32'(fifoCount), DEPTH);
    checkOutput("full no overflow yet", 32'(overflowFlag), 0);
    tick(16);
    chData[CH_DEW*DATA_W +: DATA_W] = 16'h0222;
    chReached[CH_DEW] = 1'b1;
    tick(1);
    chReached = '0;
    checkOutput("full overflow set", 32'(overflowFlag), 1);
    evtReady = 1'b1;
    tick(DEPTH);
    evtReady = 1'b0;
    checkOutput("ninth count", 32'(fifoCount), 1);
    checkOutput("ninth ch", 32'(evt.evt_ch), 32'(CH_DEW));
    checkOutput("ninth data", 32'(evt.evt_data), 32'h0222);
    evtReady = 1'b1;

    // Status clears: set beats clear.
    tick(20);
    alarmClear = '1;
    tick(1);
    alarmClear = '0;
    checkOutput("alarm cleared all", 32'(alarmStatus), 0);
    chReached[CH_MOISTURE] = 1'b1;
    alarmClear[CH_MOISTURE] = 1'b1;
    tick(1);
    chReached = '0;
    alarmClear = '0;
    checkOutput("alarm set wins", 32'(alarmStatus), 32'b01000);
    alarmClear[CH_MOISTURE] = 1'b1;
    tick(1);
    alarmClear = '0;
    checkOutput("alarm clear alone", 32'(alarmStatus), 0);
    overflowClr = 1'b1;
    tick(1);
    checkOutput("overflow cleared", 32'(overflowFlag), 0);
    tick(1);
    overflowClr = 1'b0;
    checkOutput("overflow clr idle", 32'(overflowFlag), 0);

    // Random traffic: congested then mostly flowing.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(20);
      tick(1);
    end
    for (int i = 0; i < 400; i++) begin
      applyStimulus(80);
      tick(1);
    end
    chReached = '0;
    alarmClear = '0;
    overflowClr = 1'b0;
    evtReady = 1'b1;
    tick(30);

    // Asynchronous reset with three events queued.
    evtReady = 1'b0;
    chReached = 5'b00111;
    tick(1);
    chReached = '0;
    tick(3);
    checkOutput("pre-reset count", 32'(fifoCount), 3);
    reset = 1'b0;
    #1;
    checkOutput("async reset valid", 32'(evt.evt_valid), 0);
    checkOutput("async reset count", 32'(fifoCount), 0);
    checkOutput("async reset alarm", 32'(alarmStatus), 0);
    checkOutput("async reset overflow", 32'(overflowFlag), 0);
    tick(2);
    reset = 1'b1;
    evtReady = 1'b1;
    tick(10);
    checkOutput("no stale events", 32'(evt.evt_valid), 0);
    checkOutput("no stale count", 32'(fifoCount), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
